// File: rtl/io_input_bank.sv
// rtl/io_input_bank.sv - memory-mapped input port bank: synchronise, commit, sticky change status, maskable irq
// Build option IO_INPUT_DEBOUNCE_EN adds a per-port stability window of DEBOUNCE_CYCLES before commit.
module io_input_bank #(
    parameter int NUM_PORTS       = 4,
    parameter int DATA_LEN        = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                          io_clk,
    input  logic                          rst,
    input  logic [7:0]                    addr,
    input  logic                          rd_en,
    input  logic                          wr_en,
    input  logic [DATA_LEN-1:0]           wr_data,
    input  logic [NUM_PORTS*DATA_LEN-1:0] in_ports,
    output logic [DATA_LEN-1:0]           io_read_data,
    output logic                          irq
);
    localparam logic [5:0] STATUS_IDX = 6'd14;
    localparam logic [5:0] MASK_IDX   = 6'd15;

    logic [5:0]                    word;
    logic [NUM_PORTS*DATA_LEN-1:0] data_flat;
    logic [NUM_PORTS-1:0]          commit;
    logic [NUM_PORTS-1:0]          chg_q, chg_d;
    logic [NUM_PORTS-1:0]          mask_q, mask_d;
    logic                          irq_q, irq_d;
    logic                          unused_bits;

    assign word        = addr[7:2];
    assign unused_bits = ^{addr[1:0], wr_data} ^ (DEBOUNCE_CYCLES < 1);

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [DATA_LEN-1:0] sync_q [SYNC_STAGES];
        logic [DATA_LEN-1:0] data_q;
        logic [DATA_LEN-1:0] sync_w;

        always_ff @(posedge io_clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            end else begin
                sync_q[0] <= in_ports[i*DATA_LEN +: DATA_LEN];
                for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            end
        end
        assign sync_w = sync_q[SYNC_STAGES-1];

`ifdef IO_INPUT_DEBOUNCE_EN
        localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
        logic [CW-1:0]       cnt_q, cnt_d;
        logic [DATA_LEN-1:0] prev_q;
        logic                commit_w;

        // The first cycle of a new value counts, so a stable value commits DEBOUNCE_CYCLES edges after it lands.
        always_comb begin
            cnt_d = '0;
            if (sync_w != data_q && sync_w == prev_q) cnt_d = cnt_q + 1'b1;
            commit_w = (sync_w != data_q) && (cnt_d == CW'(DEBOUNCE_CYCLES - 1));
        end

        always_ff @(posedge io_clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                prev_q <= '0;
                data_q <= '0;
            end else begin
                prev_q <= sync_w;
                if (commit_w) begin
                    data_q <= sync_w;
                    cnt_q  <= '0;
                end else begin
                    cnt_q  <= cnt_d;
                end
            end
        end
        assign commit[i] = commit_w;
`else
        always_ff @(posedge io_clk or posedge rst) begin
            if (rst) data_q <= '0;
            else     data_q <= sync_w;
        end
        assign commit[i] = (sync_w != data_q);
`endif
        assign data_flat[i*DATA_LEN +: DATA_LEN] = data_q;
    end

    // A commit in the same cycle as a status read survives the clear.
    always_comb begin
        chg_d  = ((rd_en && word == STATUS_IDX) ? '0 : chg_q) | commit;
        mask_d = (wr_en && word == MASK_IDX) ? wr_data[NUM_PORTS-1:0] : mask_q;
        irq_d  = |(chg_d & mask_d);
    end

    always_ff @(posedge io_clk or posedge rst) begin
        if (rst) begin
            chg_q  <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            chg_q  <= chg_d;
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        io_read_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (word == 6'(p)) io_read_data = data_flat[p*DATA_LEN +: DATA_LEN];
        end
        if (word == STATUS_IDX) io_read_data[NUM_PORTS-1:0] = chg_q;
        if (word == MASK_IDX)   io_read_data[NUM_PORTS-1:0] = mask_q;
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_io_input_bank.sv
// tb/tb_io_input_bank.sv - self-checking bench for io_input_bank against a delay-queue reference model
`timescale 1ns/1ps
module tb_io_input_bank;
    localparam int NP = 4;
    localparam int DL = 32;
    localparam int SS = 2;
    localparam int DC = 4;
`ifdef IO_INPUT_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int LAT = SS + (DEB ? DC : 1);

    logic           io_clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     addr = '0;
    logic           rd_en = 1'b0;
    logic           wr_en = 1'b0;
    logic [DL-1:0]  wr_data = '0;
    logic [NP*DL-1:0] in_ports = '0;
    logic [DL-1:0]  io_read_data;
    logic           irq;

    logic [7:0]     addr14 = '0;
    logic [14*32-1:0] in14 = '0;
    logic [31:0]    rd14;
    logic           unused_irq14;
    logic [7:0]     addr1 = '0;
    logic [7:0]     in1 = '0;
    logic [7:0]     rd1;
    logic           unused_irq1;

    int errors = 0;
    int checks = 0;

    logic [DL-1:0]    m_data [NP];
    logic [DL-1:0]    m_last [NP];
    int               m_run  [NP];
    logic [NP-1:0]    m_chg, m_mask;
    logic             m_irq;
    logic [NP*DL-1:0] m_pipe [$];

    io_input_bank #(.NUM_PORTS(NP), .DATA_LEN(DL), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
        .io_clk(io_clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data),
        .in_ports(in_ports), .io_read_data(io_read_data), .irq(irq)
    );
    io_input_bank #(.NUM_PORTS(14), .DATA_LEN(32), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut14 (
        .io_clk(io_clk), .rst(rst), .addr(addr14), .rd_en(1'b0), .wr_en(1'b0), .wr_data(32'h0),
        .in_ports(in14), .io_read_data(rd14), .irq(unused_irq14)
    );
    io_input_bank #(.NUM_PORTS(1), .DATA_LEN(8), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut1 (
        .io_clk(io_clk), .rst(rst), .addr(addr1), .rd_en(1'b0), .wr_en(1'b0), .wr_data(8'h0),
        .in_ports(in1), .io_read_data(rd1), .irq(unused_irq1)
    );

    always #5 io_clk = ~io_clk;

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_data[p] = '0;
            m_last[p] = '0;
            m_run[p]  = 0;
        end
        m_chg  = '0;
        m_mask = '0;
        m_irq  = 1'b0;
        m_pipe = {};
        for (int s = 0; s < SS; s++) m_pipe.push_back('0);
    endtask

    // Data seen by the commit stage is the input from SS edges ago; debounce needs DC consecutive edges of it.
    task automatic step();
        logic [NP*DL-1:0] v, s;
        logic [NP-1:0]    set, wd;
        logic             clr, wr;
        logic [DL-1:0]    sv;
        v   = in_ports;
        clr = rd_en && (addr[7:2] == 6'd14);
        wr  = wr_en && (addr[7:2] == 6'd15);
        wd  = wr_data[NP-1:0];
        @(posedge io_clk);
        #1;
        m_pipe.push_back(v);
        s   = m_pipe.pop_front();
        set = '0;
        for (int p = 0; p < NP; p++) begin
            sv = s[p*DL +: DL];
            m_run[p]  = (sv == m_last[p]) ? m_run[p] + 1 : 1;
            m_last[p] = sv;
            if (sv != m_data[p] && (!DEB || m_run[p] >= DC)) begin
                m_data[p] = sv;
                set[p]    = 1'b1;
            end
        end
        if (clr) m_chg = '0;
        m_chg = m_chg | set;
        if (wr) m_mask = wd;
        m_irq = |(m_chg & m_mask);
    endtask

    function automatic logic [DL-1:0] exp_read(input logic [7:0] a);
        logic [DL-1:0] r;
        int w;
        r = '0;
        w = int'(a[7:2]);
        if (w < NP)       r = m_data[w];
        else if (w == 14) r[NP-1:0] = m_chg;
        else if (w == 15) r[NP-1:0] = m_mask;
        return r;
    endfunction

    task automatic test_reset();
        logic [DL-1:0] e;
        rst = 1'b1;
        repeat (2) @(posedge io_clk);
        #1 rst = 1'b0;
        model_reset();
        addr = 8'h3C; wr_data = 32'hF; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        for (int p = 0; p < NP; p++) in_ports[p*DL +: DL] = $urandom | 32'h1;
        repeat (LAT + 1) step();
        #2 rst = 1'b1;
        #1;
        for (int w = 0; w < 16; w++) begin
            addr = 8'(w * 4);
            #1;
            checks++;
            if (io_read_data !== '0) begin
                errors++;
                $display("FAIL reset_read addr=%h got=%h exp=0", addr, io_read_data);
            end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        in_ports = '0;
        in_ports[DL +: DL] = 32'hA5;
        repeat (2) @(posedge io_clk);
        #1 rst = 1'b0;
        model_reset();
        addr = 8'h04;
        for (int n = 1; n <= LAT; n++) begin
            step();
            e = (n == LAT) ? 32'hA5 : 32'h0;
            checks++;
            if (io_read_data !== e) begin
                errors++;
                $display("FAIL reset_release edge=%0d got=%h exp=%h", n, io_read_data, e);
            end
        end
    endtask

    task automatic test_change_irq();
        addr = 8'h38; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        addr = 8'h3C; wr_data = 32'h2; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        checks++;
        if (io_read_data !== 32'h2) begin errors++; $display("FAIL mask_write got=%h exp=2", io_read_data); end
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) in_ports[DL +: DL] = 32'h5A;
            else            in_ports[0 +: DL]  = 32'h0000_1111;
            addr = 8'h38;
            for (int n = 1; n <= LAT; n++) begin
                step();
                checks++;
                if (io_read_data !== exp_read(addr) || irq !== m_irq) begin
                    errors++;
                    $display("FAIL change_seq ph=%0d n=%0d got=%h/%b exp=%h/%b",
                             phase, n, io_read_data, irq, exp_read(addr), m_irq);
                end
            end
            checks++;
            if (io_read_data !== ((phase == 0) ? 32'h2 : 32'h3) || irq !== 1'b1) begin
                errors++;
                $display("FAIL change_final ph=%0d got=%h/%b exp=%h/1", phase, io_read_data, irq,
                         (phase == 0) ? 32'h2 : 32'h3);
            end
        end
    endtask

    task automatic test_race();
        addr = 8'h3C; wr_data = 32'h6; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        in_ports[2*DL +: DL] = 32'hCAFE_0002;
        repeat (LAT - 1) step();
        addr = 8'h38; rd_en = 1'b1;
        #1;
        checks++;
        if (io_read_data !== 32'h3) begin errors++; $display("FAIL race_old got=%h exp=3", io_read_data); end
        step();
        rd_en = 1'b0;
        checks++;
        if (io_read_data !== 32'h4 || irq !== 1'b1) begin
            errors++;
            $display("FAIL race_new got=%h/%b exp=4/1", io_read_data, irq);
        end
        checks++;
        if (io_read_data !== exp_read(addr) || irq !== m_irq) begin
            errors++;
            $display("FAIL race_model got=%h/%b exp=%h/%b", io_read_data, irq, exp_read(addr), m_irq);
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (io_read_data !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL clear_drop got=%h/%b exp=0/0", io_read_data, irq);
        end
    endtask

    task automatic test_decode();
        logic [7:0] holes [5];
        holes = '{8'h10, 8'h20, 8'h34, 8'h40, 8'hFC};
        for (int k = 0; k < 5; k++) begin
            addr = holes[k];
            #1;
            checks++;
            if (io_read_data !== '0) begin errors++; $display("FAIL decode_hole addr=%h got=%h exp=0", addr, io_read_data); end
        end
        addr = 8'h07;
        #1;
        checks++;
        if (io_read_data !== 32'h5A) begin errors++; $display("FAIL decode_alias got=%h exp=5a", io_read_data); end
        addr = 8'h3F;
        #1;
        checks++;
        if (io_read_data !== 32'h6) begin errors++; $display("FAIL decode_alias_mask got=%h exp=6", io_read_data); end
        addr = 8'h00; wr_data = '1; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        addr = 8'h3C;
        #1;
        checks++;
        if (io_read_data !== 32'h6) begin errors++; $display("FAIL decode_wr_ignored got=%h exp=6", io_read_data); end
        addr = 8'h00;
        #1;
        checks++;
        if (io_read_data !== exp_read(addr)) begin
            errors++;
            $display("FAIL decode_data0 got=%h exp=%h", io_read_data, exp_read(addr));
        end
    endtask

    task automatic test_random();
        int p;
        logic [5:0] w;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(3) == 0) begin
                p = $urandom_range(NP - 1);
                in_ports[p*DL +: DL] = $urandom;
            end
            rd_en   = ($urandom_range(3) == 0);
            wr_en   = ($urandom_range(7) == 0);
            wr_data = $urandom;
            w       = 6'($urandom_range(17));
            addr    = ($urandom_range(2) == 0) ? 8'h38 : {w, 2'($urandom_range(3))};
            #1;
            checks++;
            if (io_read_data !== exp_read(addr)) begin
                errors++;
                $display("FAIL random_read c=%0d addr=%h got=%h exp=%h", c, addr, io_read_data, exp_read(addr));
            end
            step();
            checks++;
            if (irq !== m_irq) begin errors++; $display("FAIL random_irq c=%0d got=%b exp=%b", c, irq, m_irq); end
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic test_sweep();
        logic [31:0] e;
        logic [7:0]  e8;
        for (int p = 0; p < 14; p++) begin
            for (int b = 0; b < 32; b++) begin
                in14 = '0;
                in14[p*32 + b] = 1'b1;
                if (p < NP) begin
                    in_ports = '0;
                    in_ports[p*DL + b] = 1'b1;
                end
                if (p == 0 && b < 8) begin
                    in1 = '0;
                    in1[b] = 1'b1;
                end
                repeat (LAT) step();
                for (int q = 0; q < 14; q++) begin
                    e = '0;
                    if (q == p) e[b] = 1'b1;
                    addr14 = 8'(q * 4);
                    if (p < NP && q < NP) addr = 8'(q * 4);
                    #1;
                    checks++;
                    if (rd14 !== e) begin errors++; $display("FAIL sweep14 p=%0d b=%0d q=%0d got=%h exp=%h", p, b, q, rd14, e); end
                    if (p < NP && q < NP) begin
                        checks++;
                        if (io_read_data !== e) begin
                            errors++;
                            $display("FAIL sweep4 p=%0d b=%0d q=%0d got=%h exp=%h", p, b, q, io_read_data, e);
                        end
                    end
                end
                if (p == 0 && b < 8) begin
                    e8 = '0;
                    e8[b] = 1'b1;
                    addr1 = 8'h00;
                    #1;
                    checks++;
                    if (rd1 !== e8) begin errors++; $display("FAIL sweep1 b=%0d got=%h exp=%h", b, rd1, e8); end
                    addr1 = 8'h04;
                    #1;
                    checks++;
                    if (rd1 !== 8'h0) begin errors++; $display("FAIL sweep1_other b=%0d got=%h exp=0", b, rd1); end
                end
            end
        end
    endtask

`ifdef IO_INPUT_DEBOUNCE_EN
    task automatic test_debounce();
        logic [DL-1:0] e;
        in_ports = '0;
        repeat (LAT + 2) step();
        addr = 8'h38; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_ports[0 +: DL] = ((c % 4) < 2) ? 32'h0000_0F0F : 32'h0;
            step();
            addr = 8'h00;
            #1;
            checks++;
            if (io_read_data !== 32'h0) begin errors++; $display("FAIL debounce_data c=%0d got=%h exp=0", c, io_read_data); end
            addr = 8'h38;
            #1;
            checks++;
            if (io_read_data !== 32'h0) begin errors++; $display("FAIL debounce_status c=%0d got=%h exp=0", c, io_read_data); end
        end
        in_ports[0 +: DL] = '1;
        for (int n = 1; n <= LAT; n++) begin
            step();
            addr = 8'h00;
            #1;
            e = (n == LAT) ? '1 : '0;
            checks++;
            if (io_read_data !== e || io_read_data !== exp_read(addr)) begin
                errors++;
                $display("FAIL debounce_hold n=%0d got=%h exp=%h", n, io_read_data, e);
            end
        end
        addr = 8'h38;
        #1;
        checks++;
        if (io_read_data[0] !== 1'b1) begin errors++; $display("FAIL debounce_chg got=%h exp bit0=1", io_read_data); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_change_irq();
        test_race();
        test_decode();
        test_random();
        test_sweep();
`ifdef IO_INPUT_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_input_bank.md
# io_input_bank

Parametrised memory-mapped input port bank, the successor to the three-port input latch. It samples NUM_PORTS asynchronous input buses through a configurable synchroniser chain and holds a committed value per port. It tracks per-port change events in a sticky, clear-on-read status register and raises a maskable interrupt. It sits on the IO bus beside the output register block and is read through the same word-addressed `addr[7:2]` decode.

## Interface
- NUM_PORTS, 4: number of input ports, 1..14
- DATA_LEN, 32: width of each port and of the read bus
- SYNC_STAGES, 2: synchroniser flops per port, ≥2
- DEBOUNCE_CYCLES, 4: stability window in cycles, ≥1; used only when the debounce build option is enabled
- io_clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- addr  in  8  byte address; `addr[7:2]` selects the word
- rd_en  in  1  read strobe; qualifies clear-on-read
- wr_en  in  1  write strobe; only the mask register is writable
- wr_data  in  DATA_LEN  write data
- in_ports  in  NUM_PORTS*DATA_LEN  packed inputs; port i occupies `[i*DATA_LEN +: DATA_LEN]`
- io_read_data  out  DATA_LEN  combinational read data
- irq  out  1  registered interrupt request

## Operation
- **Synchroniser**
  - Each port passes through SYNC_STAGES flops.
  - The last stage is `sync_i`.
- **Commit**
  - Without debounce: each edge, `data_i <= sync_i`.
  - `change_i = (sync_i != data_i)` is evaluated in the same cycle.
- **Status register** (`chg`, NUM_PORTS bits)
  - Bit i is set at the edge where a commit changes `data_i`.
  - The register is cleared wholesale at the edge where `rd_en` is high and the address selects STATUS.
  - On a simultaneous set and clear, the set wins for that bit; all other bits clear.
- **Mask register** (`mask`, NUM_PORTS bits)
  - Written from `wr_data[NUM_PORTS-1:0]` at the edge where `wr_en` is high and the address selects MASK.
  - `wr_en` to any other address is ignored.
- **Interrupt**: `irq <= |(chg_next & mask_next)` each edge.
- **Address map** (word index = `addr[7:2]`):
  - 0..NUM_PORTS-1: `data_i`
  - 14 (0x38): STATUS, zero-extended
  - 15 (0x3C): MASK, zero-extended
  - any other index reads 0
  - `addr[1:0]` is ignored
- `io_read_data` is purely combinational from `addr` and registers; it is independent of `rd_en`. The clear is visible on the next read.
- **Reset**: all synchroniser flops, `data_i`, `chg`, `mask`, counters and `irq` go to 0. `io_read_data` then reads 0 at every address.
- **Reset mid-operation**: in-flight synchroniser contents and pending status bits are discarded; there is no recovery of lost events.

## Timing
- For an input change settling before edge k:
  - `sync_i` updates at edge k+SYNC_STAGES-1.
  - `data_i` and `chg[i]` update at edge k+SYNC_STAGES.
  - `irq` updates at the same edge, if `mask[i]` is set (`irq` uses next-state values).
- A change shorter than one io_clk period may be missed; this is not an error.
- A read-clear at edge m: STATUS reads 0 from edge m, and `irq` drops at edge m unless a new masked change is set in that cycle.
- A mask write takes effect for `irq` at the same edge.

## Configuration
- Macro: `IO_INPUT_DEBOUNCE_EN`.
- **Defined**: each port has a `$clog2(DEBOUNCE_CYCLES+1)`-bit counter and a `prev_i` register.
  - The counter resets to 0 when `sync_i == data_i` or `sync_i != prev_i`; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with `sync_i != data_i`, the port commits: `data_i <= sync_i`, `chg[i]` is set, and the counter returns to 0.
  - A stable new value therefore commits DEBOUNCE_CYCLES edges after it appears at `sync_i`.
- **Undefined**: counters and `prev_i` are not built; commit is immediate as in Operation.

## Test plan
- **Reset**: assert rst mid-cycle with `in_ports` nonzero → all reads return 0x0 at once and `irq=0`. Deassert with port1=0x0000_00A5 → `addr=0x04` reads 0xA5 after SYNC_STAGES+1 edges.
- **Change and interrupt**: mask=0x2 (write 0x2 to 0x3C); change port1 0xA5→0x5A → STATUS=0x2 and `irq=1` on the same edge. Change port0 → STATUS=0x3 and `irq` stays 1.
- **Clear-on-read race**: read 0x38 with rd_en in the same cycle a port2 commit occurs → the read returns the old value, the next STATUS read is 0x4, and irq follows `mask[2]`.
- **Decode**: read 0x10 with NUM_PORTS=4, and 0x20 → 0x0. Write to 0x00 → no register changes. Check `addr[1:0]`=2'b11 aliases to the word.
- **Debounce** (macro defined, DEBOUNCE_CYCLES=4): toggle port0 every 2 cycles → `data_0` and STATUS unchanged. Hold 0xFFFF_FFFF → commit exactly 4 edges after it reaches `sync_0`, with STATUS bit0 set.
- **Width/parameter sweep**: NUM_PORTS=1, DATA_LEN=8 and NUM_PORTS=14, DATA_LEN=32 → a walking-ones pattern per port reads back on its own address only.
